// File: rtl/histogram_readout.sv
// histogram_readout
//   Reader side of the histogram bin-read interface. A rising edge on histo_done
//   puts the histogram into read mode, sweeps every bin, captures each count and
//   streams one frame: a header word, NUM_BINS count words and a checksum word.
//
// Ports
//   clk         single clock, all logic on posedge
//   rst_n       asynchronous active-low reset
//   histo_done  histogram complete; rising edge starts a frame
//   hist_rw     1 = histogram accumulate mode, 0 = read mode (low for a whole frame)
//   hist_bin    bin address presented to the histogram
//   hist_data   count of hist_bin, valid READ_LAT cycles after hist_bin changes
//   out_data    stream word (header / zero-extended count / checksum)
//   out_valid   out_data valid
//   out_ready   downstream accepts when out_valid & out_ready
//   out_last    high with the checksum word, the final word of a frame
//   busy        frame in progress
//   overrun     one-cycle pulse: histo_done rising edge seen while busy
//   state_dbg   current FSM state, for observation only
//
// Stream handshake: a word transfers on a rising clk edge where out_valid and
// out_ready are both high. Once out_valid rises, out_valid, out_data and out_last
// hold their values until that transfer; out_ready is ignored while out_valid is low.

module histogram_readout #(
  parameter int BIN_W    = 10,
  parameter int CNT_W    = 24,
  parameter int READ_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             histo_done,
  output logic             hist_rw,
  output logic [BIN_W-1:0] hist_bin,
  input  logic [CNT_W-1:0] hist_data,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             overrun,
  output logic [2:0]       state_dbg
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HDR  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] SEND = 3'd3;
  localparam logic [2:0] CSUM = 3'd4;

  // The latency counter runs 0..READ_LAT-1 while waiting for hist_data.
  localparam int              LAT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT - 1);
  localparam logic [BIN_W-1:0] BIN_LAST = '1;

  logic [2:0]       state;
  logic             histo_done_q;
  logic [LAT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] held;
  logic [15:0]      frame_id;
  logic [31:0]      checksum;
  logic             start;

  assign start     = histo_done & ~histo_done_q;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Stream outputs are decoded from the state and registers that only change on
  // a transfer, so they are inherently stable while the downstream stalls.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state)
      HDR: begin
        out_valid = 1'b1;
        out_data  = {16'hA55A, frame_id};
      end
      SEND: begin
        out_valid = 1'b1;
        out_data  = 32'(held);
      end
      CSUM: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = checksum;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      histo_done_q <= 1'b0;
      hist_rw      <= 1'b1;
      hist_bin     <= '0;
      lat_cnt      <= '0;
      held         <= '0;
      frame_id     <= '0;
      checksum     <= '0;
      overrun      <= 1'b0;
    end else begin
      histo_done_q <= histo_done;
      overrun      <= start && (state != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            state    <= HDR;
            hist_rw  <= 1'b0;
            hist_bin <= '0;
            checksum <= '0;
          end
        end
        HDR: begin
          if (out_ready) begin
            state   <= WAIT;
            lat_cnt <= '0;
          end
        end
        WAIT: begin
          // hist_bin last changed on the edge that entered WAIT (or earlier,
          // for bin 0), so READ_LAT cycles here guarantee valid hist_data.
          if (lat_cnt == LAT_LAST) begin
            held  <= hist_data;
            state <= SEND;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        SEND: begin
          if (out_ready) begin
            checksum <= checksum + 32'(held);
            if (hist_bin == BIN_LAST) begin
              state <= CSUM;
            end else begin
              hist_bin <= hist_bin + BIN_W'(1);
              lat_cnt  <= '0;
              state    <= WAIT;
            end
          end
        end
        CSUM: begin
          if (out_ready) begin
            frame_id <= frame_id + 16'd1;
            hist_rw  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_histogram_readout.sv
module tb_histogram_readout;

  localparam int BIN_W    = 10;
  localparam int CNT_W    = 24;
  localparam int READ_LAT = 2;
  localparam int NUM_BINS = 1 << BIN_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             histo_done;
  logic             out_ready;
  logic             hist_rw;
  logic [BIN_W-1:0] hist_bin;
  logic [CNT_W-1:0] hist_q;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_last;
  logic             busy;
  logic             overrun;
  logic [2:0]       state_dbg;

  histogram_readout #(.BIN_W(BIN_W), .CNT_W(CNT_W), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .histo_done(histo_done), .hist_rw(hist_rw),
    .hist_bin(hist_bin), .hist_data(hist_q), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .overrun(overrun), .state_dbg(state_dbg)
  );

  // Histogram model: count of a bin appears READ_LAT cycles after the address.
  logic [CNT_W-1:0] hist_mem [NUM_BINS];
  always @(posedge clk) hist_q <= hist_mem[hist_bin];

  // Second build: small histogram, READ_LAT = 4, ready always high.
  logic        x_histo_done;
  logic        x_ready = 1'b1;
  logic        x_rw, x_valid, x_last, x_busy, x_ovr;
  logic [2:0]  x_bin;
  logic [2:0]  x_state;
  logic [23:0] x_p1, x_p2, x_p3;
  logic [31:0] x_data;

  histogram_readout #(.BIN_W(3), .CNT_W(24), .READ_LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .histo_done(x_histo_done), .hist_rw(x_rw),
    .hist_bin(x_bin), .hist_data(x_p3), .out_data(x_data),
    .out_valid(x_valid), .out_ready(x_ready), .out_last(x_last),
    .busy(x_busy), .overrun(x_ovr), .state_dbg(x_state)
  );

  always @(posedge clk) begin
    x_p1 <= 24'(x_bin);
    x_p2 <= x_p1;
    x_p3 <= x_p2;
  end

  // ---------------- scoreboard state ----------------
  logic [32:0] exp_q[$];
  logic [32:0] x_obs[$];
  int          x_cyc_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          ovr_cnt = 0;
  int          rdy_mode = 0;   // 0 manual, 1 always ready, 2 random
  logic [15:0] model_fid = 16'd0;
  logic        stall_q = 1'b0;
  logic [31:0] stall_data;
  logic        stall_last;
  logic [2:0]  stall_state;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Observes both DUTs on the falling edge, between input updates.
  task automatic sample();
    logic [32:0] e;
    cyc++;
    if (!rst_n) begin
      stall_q = 1'b0;
      return;
    end
    if (overrun) ovr_cnt++;
    if (stall_q) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", out_data, stall_data);
      chk("stall_last", 32'(out_last), 32'(stall_last));
      chk("stall_state", 32'(state_dbg), 32'(stall_state));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL extra_word: got 0x%08h expected no word (cycle %0d)", out_data, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", out_data, e[31:0]);
        chk("word_last", 32'(out_last), 32'(e[32]));
      end
    end
    stall_q     = out_valid && !out_ready;
    stall_data  = out_data;
    stall_last  = out_last;
    stall_state = state_dbg;
    if (x_valid && x_ready) begin
      x_obs.push_back({x_last, x_data});
      x_cyc_q.push_back(cyc);
    end
  endtask

  // One clock: monitor on negedge, then new inputs just after posedge.
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    if (rdy_mode == 1) out_ready = 1'b1;
    else if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
  endtask

  // ---------------- reference model ----------------
  task automatic fill_mem(input int mode);
    for (int b = 0; b < NUM_BINS; b++) begin
      if (mode == 0) hist_mem[b] = CNT_W'(b);
      else if (mode == 1) hist_mem[b] = CNT_W'($urandom);
      else hist_mem[b] = '1;
    end
  endtask

  task automatic build_frame();
    logic [31:0] sum = 32'd0;
    exp_q.push_back({1'b0, 16'hA55A, model_fid});
    for (int b = 0; b < NUM_BINS; b++) begin
      exp_q.push_back({1'b0, 32'(hist_mem[b])});
      sum = sum + 32'(hist_mem[b]);
    end
    exp_q.push_back({1'b1, sum});
  endtask

  task automatic start_frame();
    build_frame();
    tick();
    histo_done = 1'b1;
    tick();
    histo_done = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 20000) begin
      tick();
      n++;
    end
    if (n >= 20000) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got %0d words left expected 0", name, exp_q.size());
    end
    chk({name, "_rw_after"}, 32'(hist_rw), 32'd1);
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
    chk({name, "_words_left"}, 32'(exp_q.size()), 32'd0);
    model_fid = model_fid + 16'd1;
  endtask

  task automatic wait_bin(input int b);
    int n = 0;
    while (!(busy && hist_bin == BIN_W'(b)) && n < 20000) begin
      tick();
      n++;
    end
    if (n >= 20000) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_bin: got bin %0d expected %0d", hist_bin, b);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic             hd;
    logic             rdy;
    logic             e_busy;
    logic             e_rw;
    logic             e_valid;
    logic             e_last;
    logic [BIN_W-1:0] e_bin;
    logic [31:0]      e_data;
  } vec_t;

  function automatic vec_t mk(logic hd, logic rdy, logic b, logic rw, logic v,
                              logic l, logic [BIN_W-1:0] bin, logic [31:0] d);
    vec_t t;
    t.hd = hd; t.rdy = rdy; t.e_busy = b; t.e_rw = rw;
    t.e_valid = v; t.e_last = l; t.e_bin = bin; t.e_data = d;
    return t;
  endfunction

  vec_t tbl[12];

  initial begin
    int ov0;
    // expected fields describe the outputs seen before the row's inputs are applied
    tbl[0]  = mk(0, 0, 0, 1, 0, 0, 0, 32'h0);
    tbl[1]  = mk(1, 0, 0, 1, 0, 0, 0, 32'h0);
    tbl[2]  = mk(1, 0, 1, 0, 1, 0, 0, 32'hA55A0000);   // header, stalled
    tbl[3]  = mk(0, 1, 1, 0, 1, 0, 0, 32'hA55A0000);   // held-high done: no retrigger
    tbl[4]  = mk(0, 1, 1, 0, 0, 0, 0, 32'h0);          // waiting on read latency
    tbl[5]  = mk(0, 1, 1, 0, 0, 0, 0, 32'h0);
    tbl[6]  = mk(0, 1, 1, 0, 1, 0, 0, 32'h0);          // count of bin 0
    tbl[7]  = mk(0, 1, 1, 0, 0, 0, 1, 32'h0);
    tbl[8]  = mk(0, 1, 1, 0, 0, 0, 1, 32'h0);
    tbl[9]  = mk(0, 0, 1, 0, 1, 0, 1, 32'h1);          // count of bin 1, stalled
    tbl[10] = mk(0, 1, 1, 0, 1, 0, 1, 32'h1);
    tbl[11] = mk(0, 1, 1, 0, 0, 0, 2, 32'h0);

    rst_n        = 1'b0;
    histo_done   = 1'b0;
    x_histo_done = 1'b0;
    out_ready    = 1'b0;
    fill_mem(0);
    tick();
    tick();
    chk("rst_rw", 32'(hist_rw), 32'd1);
    chk("rst_bin", 32'(hist_bin), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;

    // Frame 1: identity counts, directed start then ready held high.
    build_frame();
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("vec%0d_rw", i), 32'(hist_rw), 32'(tbl[i].e_rw));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d_last", i), 32'(out_last), 32'(tbl[i].e_last));
      chk($sformatf("vec%0d_bin", i), 32'(hist_bin), 32'(tbl[i].e_bin));
      chk($sformatf("vec%0d_overrun", i), 32'(overrun), 32'd0);
      if (tbl[i].e_valid) chk($sformatf("vec%0d_data", i), out_data, tbl[i].e_data);
      histo_done = tbl[i].hd;
      out_ready  = tbl[i].rdy;
    end
    rdy_mode = 1;
    wait_frame("f1");

    // Frame 2: random counts, random backpressure.
    fill_mem(1);
    rdy_mode = 2;
    start_frame();
    wait_frame("f2");

    // Frame 3: saturated counts, checksum wraps.
    fill_mem(2);
    rdy_mode = 1;
    start_frame();
    wait_frame("f3");

    // Frame 4: second start mid-frame is ignored but flagged once.
    fill_mem(0);
    ov0 = ovr_cnt;
    start_frame();
    wait_bin(100);
    histo_done = 1'b1;
    tick();
    histo_done = 1'b0;
    wait_frame("f4");
    chk("f4_overrun_pulses", 32'(ovr_cnt - ov0), 32'd1);

    // Frame 5: reset mid-frame abandons it.
    start_frame();
    wait_bin(500);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_rw", 32'(hist_rw), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_last", 32'(out_last), 32'd0);
    exp_q.delete();
    model_fid = 16'd0;
    tick();
    rst_n = 1'b1;

    // Frame 6: full frame after reset restarts frame numbering.
    rdy_mode = 2;
    start_frame();
    wait_frame("f6");

    // READ_LAT = 4 build: counts still line up, count words every 5 cycles.
    rdy_mode = 1;
    tick();
    x_histo_done = 1'b1;
    tick();
    x_histo_done = 1'b0;
    for (int n = 0; n < 500 && x_obs.size() < 10; n++) tick();
    chk("x_words", 32'(x_obs.size()), 32'd10);
    if (x_obs.size() == 10) begin
      chk("x_header", x_obs[0][31:0], 32'hA55A0000);
      for (int k = 1; k <= 8; k++) begin
        chk($sformatf("x_count%0d", k - 1), x_obs[k][31:0], 32'(k - 1));
        chk($sformatf("x_last%0d", k - 1), 32'(x_obs[k][32]), 32'd0);
      end
      chk("x_csum", x_obs[9][31:0], 32'd28);
      chk("x_csum_last", 32'(x_obs[9][32]), 32'd1);
      for (int k = 1; k < 8; k++)
        chk($sformatf("x_spacing%0d", k), 32'(x_cyc_q[k + 1] - x_cyc_q[k]), 32'd5);
    end
    tick();
    chk("x_rw_after", 32'(x_rw), 32'd1);
    chk("x_busy_after", 32'(x_busy), 32'd0);
    chk("x_overrun", 32'(x_ovr), 32'd0);
    chk("x_state_idle", 32'(x_state), 32'(state_dbg));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
